ready_valid_fifo: RTL and testbench

READY_VALID_FIFO -- requirements
Module: ready_valid_fifo

---
 rtl/ready_valid_fifo.sv | 120 ++++++++++++
 tb/tb_ready_valid_fifo.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/ready_valid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ready_valid_fifo
// Brief    : Register-based FIFO with ready/valid handshakes on both sides.
//            One-hot write and read pointers, an AND-OR read mux, and
//            occupancy flags decoded from the registered count.
// Revision : 1.0 - initial release
// ============================================================================
module ready_valid_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [DATA_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  output logic                         rd_valid,
  output logic [DATA_WIDTH-1:0]        rd_data,
  input  logic                         rd_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         empty,
  output logic                         almost_empty,
  output logic                         almost_full,
  output logic                         full
);

  localparam int c_cnt_w = $clog2(DEPTH+1);
  localparam logic [c_cnt_w-1:0] c_zero     = '0;
  localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);
  localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(DEPTH);
  localparam logic [c_cnt_w-1:0] c_depth_m1 = c_cnt_w'(DEPTH - 1);
  localparam logic [DEPTH-1:0]   c_ptr_init = DEPTH'(1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_wr_ptr;
  logic [DEPTH-1:0]      r_rd_ptr;
  logic [c_cnt_w-1:0]    r_count;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Flags come straight from the registered count, so the handshake inputs
  // never reach them combinationally.
  assign w_empty      = (r_count == c_zero);
  assign w_full       = (r_count == c_depth);
  assign empty        = w_empty;
  assign full         = w_full;
  assign almost_empty = (r_count == c_one);
  assign almost_full  = (r_count == c_depth_m1);
  assign count        = r_count;
  assign wr_ready     = ~w_full;
  assign rd_valid     = ~w_empty;

  // A transfer needs both handshake halves; rst blocks the non-reset storage
  // writes on an edge where reset is held.
  assign w_push = wr_valid & ~w_full & ~rst;
  assign w_pop  = rd_ready & ~w_empty & ~rst;

  // Storage entries: written only on a push aimed at them, never reset.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
      always_ff @(posedge clk) begin
        if (w_push && r_wr_ptr[gi]) begin
          r_mem[gi] <= wr_data;
        end
      end
    end
  endgenerate

  // Write pointer rotates left by one per push, wrapping top bit to bit 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= c_ptr_init;
    end else if (w_push) begin
      r_wr_ptr <= {r_wr_ptr[DEPTH-2:0], r_wr_ptr[DEPTH-1]};
    end
  end

  // Read pointer rotates left by one per pop with the same wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= c_ptr_init;
    end else if (w_pop) begin
      r_rd_ptr <= {r_rd_ptr[DEPTH-2:0], r_rd_ptr[DEPTH-1]};
    end
  end

  // Occupancy: up on push-only, down on pop-only, hold otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= c_zero;
    end else if (w_push && !w_pop) begin
      r_count <= r_count + c_one;
    end else if (!w_push && w_pop) begin
      r_count <= r_count - c_one;
    end
  end

  // AND-OR mux selecting the entry under the one-hot read pointer.
  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rd_data = w_rd_data | (r_mem[i] & {DATA_WIDTH{r_rd_ptr[i]}});
    end
  end

  assign rd_data = w_rd_data;

`ifndef SYNTHESIS
  a_count_range : assert property (@(posedge clk) disable iff (rst) r_count <= c_depth);
  a_wr_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot(r_wr_ptr));
  a_rd_onehot   : assert property (@(posedge clk) disable iff (rst) $onehot(r_rd_ptr));
`endif

endmodule
`default_nettype wire

// File: tb/tb_ready_valid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_ready_valid_fifo
// Brief    : Self-checking bench for ready_valid_fifo against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ready_valid_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int c_cnt_w = $clog2(DEPTH+1);

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               wr_valid = 1'b0;
  logic [DW-1:0]      wr_data = '0;
  logic               wr_ready;
  logic               rd_valid;
  logic [DW-1:0]      rd_data;
  logic               rd_ready = 1'b0;
  logic [c_cnt_w-1:0] count;
  logic               empty;
  logic               almost_empty;
  logic               almost_full;
  logic               full;

  int n_total = 0;
  int n_pass  = 0;

  logic [DW-1:0] model_q [$];

  ready_valid_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .count        (count),
    .empty        (empty),
    .almost_empty (almost_empty),
    .almost_full  (almost_full),
    .full         (full)
  );

  always #5 clk = ~clk;

  // Single comparison point: counts and reports every check.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Compare every output against what the queue model implies.
  task automatic check_outputs(input string ctx);
    int n;
    n = model_q.size();
    check({ctx, "_count"},    32'(count),        32'(n));
    check({ctx, "_empty"},    32'(empty),        32'(n == 0));
    check({ctx, "_aempty"},   32'(almost_empty), 32'(n == 1));
    check({ctx, "_afull"},    32'(almost_full),  32'(n == DEPTH - 1));
    check({ctx, "_full"},     32'(full),         32'(n == DEPTH));
    check({ctx, "_wr_ready"}, 32'(wr_ready),     32'(n != DEPTH));
    check({ctx, "_rd_valid"}, 32'(rd_valid),     32'(n != 0));
    if (n > 0) check({ctx, "_rd_data"}, 32'(rd_data), 32'(model_q[0]));
  endtask

  // One clock cycle: apply inputs, check state, advance model on the edge.
  task automatic step(input string ctx, input logic wv, input logic [DW-1:0] wd, input logic rr);
    bit do_push;
    bit do_pop;
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    #1;
    check_outputs(ctx);
    do_push = wv && (model_q.size() < DEPTH);
    do_pop  = rr && (model_q.size() > 0);
    @(posedge clk);
    if (do_pop)  void'(model_q.pop_front());
    if (do_push) model_q.push_back(wd);
    #1;
  endtask

  initial begin
    // Asynchronous reset with no clock edge involved.
    #1 rst = 1'b1;
    #1;
    check("reset_empty",    32'(empty),    32'd1);
    check("reset_count",    32'(count),    32'd0);
    check("reset_rd_valid", 32'(rd_valid), 32'd0);
    check("reset_wr_ready", 32'(wr_ready), 32'd1);
    check("reset_full",     32'(full),     32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // Fill to full with rd_ready low.
    step("fill0", 1'b1, 8'hA1, 1'b0);
    step("fill1", 1'b1, 8'hA2, 1'b0);
    step("fill2", 1'b1, 8'hA3, 1'b0);
    check("fill_afull_at3", 32'(almost_full), 32'd1);
    step("fill3", 1'b1, 8'hA4, 1'b0);
    check("fill_full_at4",     32'(full),     32'd1);
    check("fill_wr_ready_at4", 32'(wr_ready), 32'd0);

    // From full: push 0xFF while popping; the first push is refused.
    step("drain0", 1'b1, 8'hFF, 1'b1);
    check("drain_count_c1", 32'(count), 32'd3);
    for (int i = 1; i < 4; i++) step("drain", 1'b1, 8'hFF, 1'b1);
    check("drain_count_hold", 32'(count), 32'd3);

    // Empty out, then a single push shows up one cycle later.
    for (int i = 0; i < 3; i++) step("empty_out", 1'b0, 8'h00, 1'b1);
    check("emptied", 32'(empty), 32'd1);
    step("single", 1'b1, 8'h55, 1'b0);
    check("single_rd_data", 32'(rd_data),      32'h55);
    check("single_aempty",  32'(almost_empty), 32'd1);

    // Hold at count 2 while pushing and popping every cycle.
    step("to_two", 1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 10; i++) step("stream", 1'b1, DW'(8'h20 + i), 1'b1);
    check("stream_count", 32'(count), 32'd2);

    // Reach count 3, then reset between edges.
    step("to_three", 1'b1, 8'h30, 1'b0);
    check("pre_rst_count", 32'(count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("midrst_empty",    32'(empty),    32'd1);
    check("midrst_count",    32'(count),    32'd0);
    check("midrst_rd_valid", 32'(rd_valid), 32'd0);
    check("midrst_wr_ready", 32'(wr_ready), 32'd1);
    model_q.delete();
    // Handshakes during reset must not take effect.
    wr_valid = 1'b1;
    wr_data  = 8'hEE;
    rd_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_edge_count", 32'(count), 32'd0);
    rst = 1'b0;
    step("post_rst", 1'b1, 8'h77, 1'b0);
    check("post_rst_rd_data", 32'(rd_data), 32'h77);

    // Randomised traffic against the queue model.
    for (int i = 0; i < 10000; i++) begin
      step("rand", 1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
